link_state_ctrl: RTL and testbench

Link-state controller that generates the `valido` select for the idle-recirculation block. It watches the four deserialized byte lanes and first requires COM symbols to align every lane. It then keeps the recirculation path on the tester side while the link carries IDLE, and switches it to the mux side while the link carries data. It sits between the serial-to-parallel converters and the recirculation block, in the clk4f domain.

---
 rtl/link_state_ctrl.sv | 123 ++++++++++++
 tb/tb_link_state_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/link_state_ctrl.sv
// rtl/link_state_ctrl.sv - link-state controller producing the recirculation select (valido)
// Aligns four byte lanes on COM, then tracks IDLE vs data traffic and drops back to SYNC on lane gaps.
module link_state_ctrl #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter logic [7:0]  IDL     = 8'h7C,
  parameter int unsigned COM_CNT = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] valid_in,
  output logic       valido,
  output logic [3:0] lane_sync,
  output logic [1:0] state,
  output logic       sync_lost
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic [3:0] COM_MAX  = 4'(COM_CNT);
  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0][3:0] ccnt_q, ccnt_d;
  logic [3:0][7:0] gcnt_q, gcnt_d;
  logic [3:0]      lane_sync_q, lane_sync_d;
  logic            valido_q, valido_d;
  logic            sync_lost_q, sync_lost_d;

  logic [3:0][7:0] lane_byte;
  logic            any_data, all_idle, gap_hit, link_up, timeout;

  assign lane_byte = {in3, in2, in1, in0};

  always_comb begin
    state_d     = state_q;
    ccnt_d      = ccnt_q;
    gcnt_d      = gcnt_q;
    lane_sync_d = lane_sync_q;
    any_data    = 1'b0;
    all_idle    = 1'b1;
    gap_hit     = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (valid_in[i] && lane_byte[i] != COM && lane_byte[i] != IDL) any_data = 1'b1;
      if (!(valid_in[i] && lane_byte[i] == IDL)) all_idle = 1'b0;
      // Timeout fires on the edge whose increment would land on TIMEOUT.
      if (!valid_in[i] && gcnt_q[i] == GAP_LAST) gap_hit = 1'b1;
    end

    link_up = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    timeout = link_up && gap_hit;

    case (state_q)
      ST_RESET: state_d = ST_SYNC;
      ST_SYNC: begin
        for (int i = 0; i < 4; i++) begin
          if (valid_in[i]) begin
            if (lane_byte[i] == COM) begin
              ccnt_d[i] = (ccnt_q[i] == COM_MAX) ? ccnt_q[i] : ccnt_q[i] + 4'd1;
            end else begin
              ccnt_d[i] = 4'd0;
            end
          end
          lane_sync_d[i] = (ccnt_d[i] == COM_MAX);
        end
        if (lane_sync_q == 4'hF) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        for (int i = 0; i < 4; i++) begin
          gcnt_d[i] = valid_in[i] ? 8'd0 : gcnt_q[i] + 8'd1;
        end
        if (timeout) begin
          state_d     = ST_SYNC;
          ccnt_d      = '0;
          gcnt_d      = '0;
          lane_sync_d = '0;
        end else if (state_q == ST_IDLE && any_data) begin
          state_d = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE && all_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase

    valido_d    = (state_d == ST_ACTIVE);
    sync_lost_d = timeout;
  end

  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      ccnt_q      <= '0;
      gcnt_q      <= '0;
      lane_sync_q <= '0;
      valido_q    <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ccnt_q      <= ccnt_d;
      gcnt_q      <= gcnt_d;
      lane_sync_q <= lane_sync_d;
      valido_q    <= valido_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign valido    = valido_q;
  assign lane_sync = lane_sync_q;
  assign state     = state_q;
  assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_link_state_ctrl.sv
// tb/tb_link_state_ctrl.sv - directed self-checking bench for link_state_ctrl
module tb_link_state_ctrl;

  logic       clk4f;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid_in;
  logic       valido;
  logic [3:0] lane_sync;
  logic [1:0] state;
  logic       sync_lost;

  int tests_run;
  int tests_failed;

  link_state_ctrl dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .valid_in  (valid_in),
    .valido    (valido),
    .lane_sync (lane_sync),
    .state     (state),
    .sync_lost (sync_lost)
  );

  initial begin
    clk4f = 1'b0;
    forever #5 clk4f = ~clk4f;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk4f);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    valid_in = v;
    in0 = b0;
    in1 = b1;
    in2 = b2;
    in3 = b3;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    drive(4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);

    repeat (3) step();
    check("rst_state", state, 0);
    check("rst_valido", valido, 0);
    check("rst_lane_sync", lane_sync, 0);
    check("rst_sync_lost", sync_lost, 0);

    reset = 1'b1;
    step();
    check("rel_state_sync", state, 1);
    repeat (3) step();
    check("align3_lane_sync", lane_sync, 4'h0);
    step();
    check("align4_lane_sync", lane_sync, 4'hF);
    check("align4_state", state, 1);
    check("align4_valido", valido, 0);
    step();
    check("align_idle_state", state, 2);
    check("align_idle_valido", valido, 0);

    drive(4'hF, 8'h55, 8'h7C, 8'h7C, 8'h7C);
    step();
    check("data_state", state, 3);
    check("data_valido", valido, 1);
    drive(4'hF, 8'h7C, 8'h7C, 8'h7C, 8'h7C);
    step();
    check("idle_state", state, 2);
    check("idle_valido", valido, 0);
    drive(4'hF, 8'h55, 8'h7C, 8'h7C, 8'h7C);
    step();
    check("data2_state", state, 3);
    drive(4'hF, 8'h7C, 8'h7C, 8'h7C, 8'hAA);
    step();
    check("mix_state", state, 3);
    check("mix_valido", valido, 1);
    drive(4'hF, 8'h7C, 8'h7C, 8'h7C, 8'hBC);
    step();
    check("com_in_active_state", state, 3);

    drive(4'b1101, 8'h7C, 8'h00, 8'h7C, 8'hAA);
    repeat (7) step();
    check("gap7_state", state, 3);
    check("gap7_sync_lost", sync_lost, 0);
    drive(4'hF, 8'h7C, 8'h7C, 8'h7C, 8'hAA);
    step();
    check("gap_clear_state", state, 3);
    drive(4'b1101, 8'h7C, 8'h00, 8'h7C, 8'hAA);
    repeat (7) step();
    check("gap7b_state", state, 3);
    step();
    check("tmo_state", state, 1);
    check("tmo_sync_lost", sync_lost, 1);
    check("tmo_valido", valido, 0);
    check("tmo_lane_sync", lane_sync, 0);

    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 8'hBC, 8'hBC, (k == 3) ? 8'h00 : 8'hBC, 8'hBC);
      step();
      if (k == 0) check("tmo_pulse_end", sync_lost, 0);
      if (k == 3) check("brk_e4_lane_sync", lane_sync, 4'b1011);
      if (k == 6) check("brk_e7_lane_sync", lane_sync, 4'b1011);
      if (k == 7) begin
        check("brk_e8_lane_sync", lane_sync, 4'hF);
        check("brk_e8_state", state, 1);
      end
    end
    drive(4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    step();
    check("brk_idle_state", state, 2);
    step();
    check("com_in_idle_state", state, 2);

    drive(4'b0111, 8'h7C, 8'h7C, 8'h7C, 8'h7C);
    repeat (7) step();
    check("sim_pre_state", state, 2);
    drive(4'b0111, 8'h55, 8'h7C, 8'h7C, 8'h7C);
    step();
    check("sim_state", state, 1);
    check("sim_valido", valido, 0);
    check("sim_sync_lost", sync_lost, 1);

    drive(4'hF, 8'hBC, 8'hBC, 8'hBC, 8'hBC);
    repeat (4) step();
    check("realign_lane_sync", lane_sync, 4'hF);
    step();
    check("realign_state", state, 2);
    drive(4'hF, 8'h55, 8'h7C, 8'h7C, 8'h7C);
    step();
    check("pre_rst_state", state, 3);
    check("pre_rst_valido", valido, 1);

    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valido", valido, 0);
    check("async_rst_state", state, 0);
    check("async_rst_lane_sync", lane_sync, 0);
    check("async_rst_sync_lost", sync_lost, 0);
    step();
    check("held_rst_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
